ser_m2n: RTL and testbench
==========================

Name: ser_m2n

Overview:
- Parallel-to-serial converter. Accepts an M-bit word over a valid/ready handshake and emits it as ceil(M/N) beats of N bits each.
- Emits least-significant chunk first, so the team's N-to-M deserializer reassembles the original word in the correct order.
- Sits on the transmit side of the SERDES pair; the downstream link paces it with tx_en.
- Supports back-to-back words with no idle cycle between frames.

Parameters:
- N, 1, beat width in bits (tx width).
- M, 8, parallel word width in bits.
- BEATS, derived localparam, ceil(M/N) = (M+N-1)/N. Not user-settable.
- CW, derived localparam, max(1, $clog2(BEATS)). Beat counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_data  in  M  parallel word to transmit.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a word this cycle.
- tx_en  in  1  downstream consumes the current beat at this clock edge.
- tx  out  N  current beat.
- tx_valid  out  1  tx holds a valid beat.
- tx_sof  out  1  current beat is the first of a word.
- tx_eof  out  1  current beat is the last of a word.
- busy  out  1  a word is in flight; equal to tx_valid.

Behaviour:
- Reset is asynchronous, active-high, with clock clk.
  - State goes to IDLE; shift buffer and counter clear to 0.
  - Outputs during and after reset: tx=0, tx_valid=0, tx_sof=0, tx_eof=0, busy=0.
  - in_ready is forced to 0 while rst is high.
- Buffer and counter:
  - Shift buffer is BEATS*N bits wide. On load, in_data goes into the low M bits; the upper BEATS*N-M bits are zero padding.
  - tx = buffer[N-1:0], registered, with no combinational path from in_data.
  - cnt holds the number of beats remaining after the current one.
- Accept is defined as in_valid && in_ready at a rising edge.
- State IDLE:
  - in_ready=1, tx_valid=0.
  - On accept: load buffer, set cnt=BEATS-1, go to SHIFT.
- State SHIFT:
  - tx_valid=1, tx_sof=(cnt==BEATS-1), tx_eof=(cnt==0).
  - tx_en=0: hold everything; tx stays stable.
  - tx_en=1 and cnt!=0: shift buffer right by N (zero fill), cnt-=1.
  - tx_en=1 and cnt==0: the last beat is consumed.
    - If in_valid=1, reload from in_data, set cnt=BEATS-1, stay in SHIFT. This is back-to-back operation with no bubble.
    - Otherwise go to IDLE.
- in_ready = (state==IDLE) || (state==SHIFT && cnt==0 && tx_en). It is combinational from tx_en; downstream must not derive tx_en from in_ready.
- Latency: a word accepted at edge k shows its first beat on tx in the cycle after edge k. With tx_en held high, a frame occupies exactly BEATS cycles.
- BEATS==1 (N>=M): every beat has tx_sof=tx_eof=1. tx[M-1:0]=word and the upper N-M bits are 0.
- in_valid while not ready: the word is not taken, and in_data is ignored that cycle. The upstream must hold it (standard valid/ready).
- tx_en while tx_valid=0: ignored.
- Reset mid-frame: the frame is aborted immediately and the remaining beats are discarded. After rst deasserts, the block is in IDLE and ready.

Decomposition:
- Package ser_pkg holds:
  - function beats_f(n,m) returning ceil(m/n);
  - typedef enum logic {IDLE, SHIFT} ser_state_t.
  - The deserializer should adopt beats_f too.
- One sub-module, ser_beat_cnt: loadable down-counter with load, dec, value, and the is_first/is_last flags.
- Shift buffer and FSM live in ser_m2n.

Test Plan:
- N=1, M=8: load 8'hA5 with tx_en=1 -> tx sequence 1,0,1,0,0,1,0,1 over 8 cycles. tx_sof on beat 0, tx_eof on beat 7, then IDLE with in_ready=1.
- N=1, M=8: in_valid held with words 8'h0F then 8'hF0, tx_en=1 -> 16 consecutive valid beats with no gap. in_ready pulses high on each tx_eof cycle. Output feeds the deserializer and it recovers 0F then F0.
- N=3, M=8 (BEATS=3): load 8'hC7 -> beats 3'b111, 3'b000, 3'b011; the top bit of the last beat is padding 0.
- N=2, M=8: load 8'h1B and drop tx_en for 3 cycles after beat 1 -> tx holds 2'b10 and tx_valid stays 1 during the stall. Remaining beats 2'b01, 2'b00 follow; total frame is 7 cycles.
- N=8, M=8: words 8'h3C, 8'h81 back-to-back -> one beat each, tx_sof=tx_eof=1 every cycle, in_ready stays 1.
- Assert rst asynchronously mid-frame at beat 3 of 8'hFF (N=1) -> tx=0 and tx_valid=0 immediately. After release, a new word 8'h01 is sent cleanly starting with tx_sof.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared definitions for the SERDES serializer/deserializer pair:
// FSM state encoding and the beat-count helpers both sides derive widths from.
package ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Number of n-bit beats needed to carry an m-bit word (ceiling division).
  function automatic int beats_f(input int n, input int m);
    return (m + n - 1) / n;
  endfunction

  // Width of a counter that spans 0..beats-1, never narrower than one bit.
  function automatic int cnt_width_f(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/ser_beat_cnt.sv
// Loadable down-counter tracking how many beats of the current word remain
// after the one on the wire. Flags mark the first and last beat of a word.
module ser_beat_cnt #(
  parameter int BEATS = 8,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  output logic [CW-1:0] value,
  output logic          is_first,
  output logic          is_last
);

  localparam logic [CW-1:0] LAST_V = CW'(BEATS - 1);
  localparam logic [CW-1:0] ZERO_V = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_V  = CW'(1);

  logic [CW-1:0] value_r;

  // Beat counter: load restarts a word, dec steps toward the last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_r <= ZERO_V;
    end else if (load) begin
      value_r <= LAST_V;
    end else if (dec && (value_r != ZERO_V)) begin
      value_r <= value_r - ONE_V;
    end else begin
      value_r <= value_r;
    end
  end

  assign value    = value_r;
  assign is_first = (value_r == LAST_V);
  assign is_last  = (value_r == ZERO_V);

endmodule

// File: rtl/ser_m2n.sv
// M-to-N parallel-to-serial converter. Takes an M-bit word over valid/ready
// and emits it least-significant chunk first as ceil(M/N) beats of N bits,
// paced by tx_en from the downstream link. Back-to-back words need no bubble.
module ser_m2n
  import ser_pkg::*;
#(
  parameter int N = 1,
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [M-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         tx_en,
  output logic [N-1:0] tx,
  output logic         tx_valid,
  output logic         tx_sof,
  output logic         tx_eof,
  output logic         busy
);

  localparam int BEATS = beats_f(N, M);
  localparam int CW    = cnt_width_f(BEATS);
  localparam int BW    = BEATS * N;

  ser_state_t    state_r;
  ser_state_t    next_state_s;
  logic [BW-1:0] buf_r;
  logic [BW-1:0] load_word_s;
  logic [CW-1:0] cnt_s;
  logic          is_first_s;
  logic          is_last_s;
  logic          load_s;
  logic          shift_s;
  logic          in_ready_s;

  ser_beat_cnt #(
    .BEATS (BEATS),
    .CW    (CW)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .dec      (shift_s),
    .value    (cnt_s),
    .is_first (is_first_s),
    .is_last  (is_last_s)
  );

  // Place the incoming word in the low bits with zero padding above it.
  always_comb begin
    load_word_s          = {BW{1'b0}};
    load_word_s[M-1:0]   = in_data;
  end

  // Next-state and handshake decode; reload on the last beat keeps frames gapless.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    shift_s      = 1'b0;
    in_ready_s   = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        if (in_valid) begin
          load_s       = 1'b1;
          next_state_s = SHIFT;
        end else begin
          next_state_s = IDLE;
        end
      end
      SHIFT: begin
        if (tx_en) begin
          if (is_last_s) begin
            in_ready_s = 1'b1;
            if (in_valid) begin
              load_s       = 1'b1;
              next_state_s = SHIFT;
            end else begin
              next_state_s = IDLE;
            end
          end else begin
            shift_s      = 1'b1;
            next_state_s = SHIFT;
          end
        end else begin
          next_state_s = SHIFT;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // FSM state register; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Shift buffer: the low N bits are the beat on the wire, so tx is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_r <= {BW{1'b0}};
    end else if (load_s) begin
      buf_r <= load_word_s;
    end else if (shift_s) begin
      buf_r <= buf_r >> N;
    end else begin
      buf_r <= buf_r;
    end
  end

  assign tx       = buf_r[N-1:0];
  assign tx_valid = (state_r == SHIFT);
  assign tx_sof   = tx_valid & is_first_s;
  assign tx_eof   = tx_valid & is_last_s;
  assign busy     = tx_valid;
  assign in_ready = in_ready_s & ~rst;

endmodule

// File: tb/tb_ser_m2n.sv
// Directed bench for ser_m2n: four instances (N=1,2,3,8 with M=8) share a
// clock and reset, each exercised with hand-computed beat sequences.
module tb_ser_m2n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // N=1 instance
  logic [7:0] d1; logic v1, r1, e1; logic [0:0] t1; logic tv1, ts1, te1, b1;
  // N=2 instance
  logic [7:0] d2; logic v2, r2, e2; logic [1:0] t2; logic tv2, ts2, te2, b2;
  // N=3 instance
  logic [7:0] d3; logic v3, r3, e3; logic [2:0] t3; logic tv3, ts3, te3, b3;
  // N=8 instance
  logic [7:0] d8; logic v8, r8, e8; logic [7:0] t8; logic tv8, ts8, te8, b8;

  ser_m2n #(.N(1), .M(8)) u1 (.clk(clk), .rst(rst), .in_data(d1), .in_valid(v1),
    .in_ready(r1), .tx_en(e1), .tx(t1), .tx_valid(tv1), .tx_sof(ts1), .tx_eof(te1), .busy(b1));
  ser_m2n #(.N(2), .M(8)) u2 (.clk(clk), .rst(rst), .in_data(d2), .in_valid(v2),
    .in_ready(r2), .tx_en(e2), .tx(t2), .tx_valid(tv2), .tx_sof(ts2), .tx_eof(te2), .busy(b2));
  ser_m2n #(.N(3), .M(8)) u3 (.clk(clk), .rst(rst), .in_data(d3), .in_valid(v3),
    .in_ready(r3), .tx_en(e3), .tx(t3), .tx_valid(tv3), .tx_sof(ts3), .tx_eof(te3), .busy(b3));
  ser_m2n #(.N(8), .M(8)) u8 (.clk(clk), .rst(rst), .in_data(d8), .in_valid(v8),
    .in_ready(r8), .tx_en(e8), .tx(t8), .tx_valid(tv8), .tx_sof(ts8), .tx_eof(te8), .busy(b8));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed beat tables.
  logic [0:0] seq_a5 [8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [0:0] seq_0f [16] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [2:0] seq_c7 [3]  = '{3'b111, 3'b000, 3'b011};
  logic [1:0] seq_1b [7]  = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00};
  logic       en_1b  [7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  logic [7:0] des;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    d1 = 8'h00; v1 = 1'b0; e1 = 1'b0;
    d2 = 8'h00; v2 = 1'b0; e2 = 1'b0;
    d3 = 8'h00; v3 = 1'b0; e3 = 1'b0;
    d8 = 8'h00; v8 = 1'b0; e8 = 1'b0;
    des = 8'h00;
    #2;
    check_val("rst_tx",    32'(t1),  32'd0);
    check_val("rst_valid", 32'(tv1), 32'd0);
    check_val("rst_sof",   32'(ts1), 32'd0);
    check_val("rst_eof",   32'(te1), 32'd0);
    check_val("rst_busy",  32'(b1),  32'd0);
    check_val("rst_ready", 32'(r1),  32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_val("idle_ready1", 32'(r1), 32'd1);
    check_val("idle_ready8", 32'(r8), 32'd1);

    // N=1, single word 8'hA5, LSB first.
    tick();
    d1 = 8'hA5; v1 = 1'b1; e1 = 1'b1;
    #1;
    check_val("a5_ready", 32'(r1), 32'd1);
    tick();
    v1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_val("a5_tx",    32'(t1),  32'(seq_a5[i]));
      check_val("a5_valid", 32'(tv1), 32'd1);
      check_val("a5_sof",   32'(ts1), 32'(i == 0));
      check_val("a5_eof",   32'(te1), 32'(i == 7));
      tick();
    end
    check_val("a5_idle_valid", 32'(tv1), 32'd0);
    check_val("a5_idle_ready", 32'(r1),  32'd1);
    check_val("a5_idle_busy",  32'(b1),  32'd0);

    // N=1, back-to-back 8'h0F then 8'hF0 with in_valid held.
    d1 = 8'h0F; v1 = 1'b1; e1 = 1'b1;
    tick();
    d1 = 8'hF0;
    for (int k = 0; k < 16; k++) begin
      if (k == 8) v1 = 1'b0;
      check_val("b2b_tx",    32'(t1),  32'(seq_0f[k]));
      check_val("b2b_valid", 32'(tv1), 32'd1);
      check_val("b2b_eof",   32'(te1), 32'((k % 8) == 7));
      #1;
      check_val("b2b_ready", 32'(r1), 32'((k % 8) == 7));
      des[k % 8] = t1[0];
      if ((k % 8) == 7) begin
        check_val("b2b_deser", 32'(des), (k < 8) ? 32'h0F : 32'hF0);
      end
      tick();
    end
    check_val("b2b_idle_valid", 32'(tv1), 32'd0);

    // N=3, 8'hC7 with padding in the last beat.
    d3 = 8'hC7; v3 = 1'b1; e3 = 1'b1;
    tick();
    v3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_val("c7_tx",    32'(t3),  32'(seq_c7[i]));
      check_val("c7_valid", 32'(tv3), 32'd1);
      check_val("c7_sof",   32'(ts3), 32'(i == 0));
      check_val("c7_eof",   32'(te3), 32'(i == 2));
      tick();
    end
    check_val("c7_idle_valid", 32'(tv3), 32'd0);

    // N=2, 8'h1B with a 3-cycle stall on beat 1.
    d2 = 8'h1B; v2 = 1'b1; e2 = 1'b1;
    tick();
    v2 = 1'b0;
    for (int c = 0; c < 7; c++) begin
      e2 = en_1b[c];
      check_val("1b_tx",    32'(t2),  32'(seq_1b[c]));
      check_val("1b_valid", 32'(tv2), 32'd1);
      check_val("1b_sof",   32'(ts2), 32'(c == 0));
      check_val("1b_eof",   32'(te2), 32'(c == 6));
      tick();
    end
    check_val("1b_idle_valid", 32'(tv2), 32'd0);

    // N=8, single-beat words back-to-back.
    d8 = 8'h3C; v8 = 1'b1; e8 = 1'b1;
    #1;
    check_val("w8_ready0", 32'(r8), 32'd1);
    tick();
    check_val("w8_tx0",  32'(t8),  32'h3C);
    check_val("w8_sof0", 32'(ts8), 32'd1);
    check_val("w8_eof0", 32'(te8), 32'd1);
    d8 = 8'h81;
    #1;
    check_val("w8_ready1", 32'(r8), 32'd1);
    tick();
    check_val("w8_tx1",  32'(t8),  32'h81);
    check_val("w8_sof1", 32'(ts8), 32'd1);
    check_val("w8_eof1", 32'(te8), 32'd1);
    v8 = 1'b0;
    #1;
    check_val("w8_ready2", 32'(r8), 32'd1);
    tick();
    check_val("w8_idle_valid", 32'(tv8), 32'd0);
    check_val("w8_idle_ready", 32'(r8),  32'd1);

    // N=1, async reset at beat 3 of 8'hFF, then a clean 8'h01.
    d1 = 8'hFF; v1 = 1'b1; e1 = 1'b1;
    tick();
    v1 = 1'b0;
    repeat (3) tick();
    check_val("ff_beat3_tx",    32'(t1),  32'd1);
    check_val("ff_beat3_valid", 32'(tv1), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_val("ff_rst_tx",    32'(t1),  32'd0);
    check_val("ff_rst_valid", 32'(tv1), 32'd0);
    check_val("ff_rst_ready", 32'(r1),  32'd0);
    check_val("ff_rst_busy",  32'(b1),  32'd0);
    tick();
    rst = 1'b0;
    #1;
    check_val("post_rst_valid", 32'(tv1), 32'd0);
    check_val("post_rst_ready", 32'(r1),  32'd1);
    d1 = 8'h01; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_val("01_tx",    32'(t1),  32'(i == 0));
      check_val("01_valid", 32'(tv1), 32'd1);
      check_val("01_sof",   32'(ts1), 32'(i == 0));
      check_val("01_eof",   32'(te1), 32'(i == 7));
      tick();
    end
    check_val("01_idle_valid", 32'(tv1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
